mem_line_controller: RTL and testbench

// Sequences word-wide main memory on behalf of the cache: converts whole-line

---
 rtl/mem_line_controller_if.sv | 50 +++++
 rtl/mem_line_controller.sv | 143 ++++++++++++++
 tb/tb_mem_line_controller.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_controller_if.sv
// Bundles the cache-side request/data signals and the word-wide memory port
// of the line controller. slave = controller side, master = requester/memory side.
interface mem_line_controller_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 16
);
    localparam int OFF = $clog2(LINE_WORDS);

    logic                  fill_req;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  fill_ack;
    logic [WORD_WIDTH-1:0] fill_data;
    logic                  fill_data_valid;
    logic [OFF-1:0]        fill_word_idx;
    logic                  fill_done;
    logic                  wb_req;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic                  wb_ack;
    logic [OFF-1:0]        wb_word_idx;
    logic [WORD_WIDTH-1:0] wb_data;
    logic                  wb_done;
    logic                  busy;
    logic [WORD_WIDTH-1:0] mem_write_data;
    logic [ADDR_WIDTH-3:0] mem_write_addr;
    logic                  mem_write_en;
    logic [ADDR_WIDTH-3:0] mem_read_addr;
    logic                  mem_read_addr_valid;
    logic [WORD_WIDTH-1:0] mem_read_data;
    logic                  mem_read_ready;
    logic                  mem_read_valid;

    modport slave (
        input  fill_req, fill_addr, wb_req, wb_addr, wb_data,
               mem_read_data, mem_read_ready, mem_read_valid,
        output fill_ack, fill_data, fill_data_valid, fill_word_idx, fill_done,
               wb_ack, wb_word_idx, wb_done, busy,
               mem_write_data, mem_write_addr, mem_write_en,
               mem_read_addr, mem_read_addr_valid
    );

    modport master (
        output fill_req, fill_addr, wb_req, wb_addr, wb_data,
               mem_read_data, mem_read_ready, mem_read_valid,
        input  fill_ack, fill_data, fill_data_valid, fill_word_idx, fill_done,
               wb_ack, wb_word_idx, wb_done, busy,
               mem_write_data, mem_write_addr, mem_write_en,
               mem_read_addr, mem_read_addr_valid
    );
endinterface

// File: rtl/mem_line_controller.sv
// Turns whole-line fill and writeback requests into per-word memory reads and
// writes; one line operation at a time, writeback wins arbitration.
module mem_line_controller #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_line_controller_if.slave  bus
);
    localparam int OFF    = $clog2(LINE_WORDS);
    localparam int BASE_W = ADDR_WIDTH - 2 - OFF;
    localparam logic [OFF-1:0] LAST_IDX = OFF'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WB, RD_ISSUE, RD_WAIT} state_t;

    state_t                state_q;
    logic [BASE_W-1:0]     base_q;
    logic [OFF-1:0]        idx_q;
    logic                  wb_last_q;
    logic                  fill_ack_q;
    logic                  fill_data_valid_q;
    logic                  fill_done_q;
    logic [WORD_WIDTH-1:0] fill_data_q;
    logic [OFF-1:0]        fill_word_idx_q;
    logic                  wb_ack_q;
    logic                  wb_done_q;
    logic                  mem_write_en_q;
    logic [ADDR_WIDTH-3:0] mem_write_addr_q;
    logic [WORD_WIDTH-1:0] mem_write_data_q;
    logic                  mem_read_addr_valid_q;
    logic [ADDR_WIDTH-3:0] mem_read_addr_q;

    logic [OFF-1:0]        idx_d;
    logic [BASE_W-1:0]     fill_base_d;
    logic [BASE_W-1:0]     wb_base_d;
    logic                  unused_low_bits;

    // Byte offset within the line is irrelevant: only the line base is kept.
    assign fill_base_d     = bus.fill_addr[ADDR_WIDTH-1:OFF+2];
    assign wb_base_d       = bus.wb_addr[ADDR_WIDTH-1:OFF+2];
    assign unused_low_bits = ^{bus.fill_addr[OFF+1:0], bus.wb_addr[OFF+1:0]};
    assign idx_d           = idx_q + OFF'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q               <= IDLE;
            base_q                <= '0;
            idx_q                 <= '0;
            wb_last_q             <= 1'b0;
            fill_ack_q            <= 1'b0;
            fill_data_valid_q     <= 1'b0;
            fill_done_q           <= 1'b0;
            fill_data_q           <= '0;
            fill_word_idx_q       <= '0;
            wb_ack_q              <= 1'b0;
            wb_done_q             <= 1'b0;
            mem_write_en_q        <= 1'b0;
            mem_write_addr_q      <= '0;
            mem_write_data_q      <= '0;
            mem_read_addr_valid_q <= 1'b0;
            mem_read_addr_q       <= '0;
        end else begin
            fill_ack_q        <= 1'b0;
            fill_data_valid_q <= 1'b0;
            fill_done_q       <= 1'b0;
            wb_ack_q          <= 1'b0;
            wb_done_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Victim must leave memory before its refill can read it.
                    if (bus.wb_req) begin
                        state_q   <= WB;
                        wb_ack_q  <= 1'b1;
                        base_q    <= wb_base_d;
                        idx_q     <= '0;
                        wb_last_q <= 1'b0;
                    end else if (bus.fill_req) begin
                        state_q               <= RD_ISSUE;
                        fill_ack_q            <= 1'b1;
                        base_q                <= fill_base_d;
                        idx_q                 <= '0;
                        mem_read_addr_valid_q <= 1'b1;
                        mem_read_addr_q       <= {fill_base_d, OFF'(0)};
                    end
                end
                WB: begin
                    if (wb_last_q) begin
                        mem_write_en_q <= 1'b0;
                        wb_done_q      <= 1'b1;
                        wb_last_q      <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        mem_write_en_q   <= 1'b1;
                        mem_write_addr_q <= {base_q, idx_q};
                        mem_write_data_q <= bus.wb_data;
                        idx_q            <= idx_d;
                        wb_last_q        <= (idx_q == LAST_IDX);
                    end
                end
                RD_ISSUE: begin
                    if (bus.mem_read_ready) begin
                        mem_read_addr_valid_q <= 1'b0;
                        state_q               <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_read_valid) begin
                        fill_data_q       <= bus.mem_read_data;
                        fill_word_idx_q   <= idx_q;
                        fill_data_valid_q <= 1'b1;
                        if (idx_q == LAST_IDX) begin
                            fill_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            idx_q                 <= idx_d;
                            mem_read_addr_q       <= {base_q, idx_d};
                            mem_read_addr_valid_q <= 1'b1;
                            state_q               <= RD_ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fill_ack            = fill_ack_q;
    assign bus.fill_data           = fill_data_q;
    assign bus.fill_data_valid     = fill_data_valid_q;
    assign bus.fill_word_idx       = fill_word_idx_q;
    assign bus.fill_done           = fill_done_q;
    assign bus.wb_ack              = wb_ack_q;
    assign bus.wb_word_idx         = idx_q;
    assign bus.wb_done             = wb_done_q;
    assign bus.busy                = (state_q != IDLE);
    assign bus.mem_write_en        = mem_write_en_q;
    assign bus.mem_write_addr      = mem_write_addr_q;
    assign bus.mem_write_data      = mem_write_data_q;
    assign bus.mem_read_addr_valid = mem_read_addr_valid_q;
    assign bus.mem_read_addr       = mem_read_addr_q;
endmodule

// File: tb/tb_mem_line_controller.sv
// Scoreboard bench for mem_line_controller: stimulus plans expected memory
// traffic and fill words from a line-level memory model; one monitor compares.
`timescale 1ns/1ps
module tb_mem_line_controller;
    localparam int WW  = 32;
    localparam int AW  = 32;
    localparam int LW  = 4;
    localparam int OFF = 2;

    typedef struct packed { logic [AW-3:0] addr; logic [WW-1:0] data; } wr_t;
    typedef struct packed { logic [WW-1:0] data; logic [OFF-1:0] idx; logic last; } fe_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_line_controller_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) bus();
    mem_line_controller #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int fill_done_cnt = 0, wb_done_cnt = 0, fill_valid_cnt = 0, in_flight = 0;

    wr_t            wq[$];
    fe_t            fq[$];
    logic [AW-3:0]  rq[$];
    int             stall_q[$];
    string          sq_name[$];
    logic [191:0]   sq_act[$];
    logic [191:0]   sq_exp[$];

    logic [WW-1:0] ref_mem  [int];
    logic [WW-1:0] phys_mem [int];
    logic [WW-1:0] wb_line  [LW];

    assign bus.wb_data = wb_line[bus.wb_word_idx];

    function automatic logic [WW-1:0] init_word(input int a);
        if (a >= 'h40 && a < 'h44) return WW'('hA0 + (a - 'h40));
        return WW'(32'h5EED_0000 ^ (a * 7));
    endfunction

    function automatic logic [WW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [WW-1:0] phys_rd(input int a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    task automatic cmp(input string n, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic req_check(input string n, input logic [191:0] act, input logic [191:0] exp);
        sq_name.push_back(n);
        sq_act.push_back(act);
        sq_exp.push_back(exp);
    endtask

    // Monitor plus memory responder; the only process that compares.
    logic          rdy;
    int            pend = 0;
    int            stall_left = 0;
    logic [AW-3:0] pend_addr, stall_addr;
    wr_t           we;
    fe_t           fe;
    always @(negedge clk) begin
        while (sq_name.size() > 0) cmp(sq_name.pop_front(), sq_act.pop_front(), sq_exp.pop_front());
        if (rst) begin
            if (bus.fill_ack || bus.wb_ack) begin
                cmp("one_op_in_flight", 192'(in_flight), 192'(0));
                in_flight++;
                if (bus.fill_ack) cmp("wb_priority", 192'(bus.wb_req), 192'(0));
            end
            if (bus.mem_write_en) begin
                cmp("no_read_during_write", 192'(bus.mem_read_addr_valid), 192'(0));
                if (wq.size() == 0) cmp("unexpected_write", 192'(1), 192'(0));
                else begin
                    we = wq.pop_front();
                    cmp("wr_addr", 192'(bus.mem_write_addr), 192'(we.addr));
                    cmp("wr_data", 192'(bus.mem_write_data), 192'(we.data));
                end
                phys_mem[int'(bus.mem_write_addr)] = bus.mem_write_data;
            end
            if (bus.wb_done) begin
                wb_done_cnt++;
                in_flight--;
                cmp("wb_done_after_all_writes", 192'(wq.size()), 192'(0));
            end
            if (bus.fill_data_valid) begin
                fill_valid_cnt++;
                if (fq.size() == 0) cmp("unexpected_fill_word", 192'(1), 192'(0));
                else begin
                    fe = fq.pop_front();
                    cmp("fill_data", 192'(bus.fill_data), 192'(fe.data));
                    cmp("fill_word_idx", 192'(bus.fill_word_idx), 192'(fe.idx));
                    cmp("fill_done_with_last", 192'(bus.fill_done), 192'(fe.last));
                end
            end
            if (bus.fill_done) begin
                fill_done_cnt++;
                in_flight--;
                if (!bus.fill_data_valid) cmp("fill_done_without_valid", 192'(1), 192'(0));
            end
            bus.mem_read_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_read_valid = 1'b1;
                    bus.mem_read_data  = phys_rd(int'(pend_addr));
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (stall_left == 0 && stall_q.size() > 0 && bus.mem_read_addr_valid) begin
                stall_left = stall_q.pop_front();
                stall_addr = bus.mem_read_addr;
            end else if (stall_left > 0) begin
                cmp("stall_addr_valid_held", 192'(bus.mem_read_addr_valid), 192'(1));
                cmp("stall_addr_stable", 192'(bus.mem_read_addr), 192'(stall_addr));
                cmp("stall_no_fill_valid", 192'(bus.fill_data_valid), 192'(0));
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            bus.mem_read_ready = rdy;
            if (rdy && bus.mem_read_addr_valid) begin
                if (rq.size() == 0) cmp("unexpected_read", 192'(1), 192'(0));
                else cmp("rd_addr", 192'(bus.mem_read_addr), 192'(rq.pop_front()));
                pend      = $urandom_range(1, 3);
                pend_addr = bus.mem_read_addr;
            end
        end else begin
            wq.delete(); fq.delete(); rq.delete();
            pend = 0; stall_left = 0; in_flight = 0;
            bus.mem_read_valid = 1'b0;
            bus.mem_read_ready = 1'b0;
            bus.mem_read_data  = '0;
        end
    end

    task automatic plan_fill(input logic [AW-1:0] a);
        int base;
        fe_t e;
        base = int'(a >> (OFF + 2));
        for (int k = 0; k < LW; k++) begin
            rq.push_back((AW-2)'(base * LW + k));
            e.data = ref_rd(base * LW + k);
            e.idx  = OFF'(k);
            e.last = (k == LW - 1);
            fq.push_back(e);
        end
    endtask

    task automatic plan_wb(input logic [AW-1:0] a, input bit rnd, input logic [WW-1:0] pat);
        int  base;
        wr_t e;
        base = int'(a >> (OFF + 2));
        for (int k = 0; k < LW; k++) begin
            wb_line[k] = rnd ? WW'($urandom) : pat + WW'(k);
            e.addr = (AW-2)'(base * LW + k);
            e.data = wb_line[k];
            wq.push_back(e);
            ref_mem[base * LW + k] = wb_line[k];
        end
    endtask

    task automatic wait_fill_done(input int d0);
        for (int t = 0; t < 3000 && fill_done_cnt == d0; t++) @(negedge clk);
        req_check("fill_done_seen", 192'(fill_done_cnt != d0), 192'(1));
    endtask

    task automatic wait_wb_done(input int d0);
        for (int t = 0; t < 3000 && wb_done_cnt == d0; t++) @(negedge clk);
        req_check("wb_done_seen", 192'(wb_done_cnt != d0), 192'(1));
    endtask

    task automatic run_fill(input logic [AW-1:0] a);
        int   d0;
        logic got;
        d0 = fill_done_cnt;
        plan_fill(a);
        bus.fill_addr = a;
        bus.fill_req  = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.fill_ack) break;
        end
        got = bus.fill_ack;
        bus.fill_req = 1'b0;
        req_check("fill_ack_seen", 192'(got), 192'(1));
        wait_fill_done(d0);
    endtask

    task automatic run_wb(input logic [AW-1:0] a, input bit rnd, input logic [WW-1:0] pat);
        int   d0;
        logic got;
        d0 = wb_done_cnt;
        plan_wb(a, rnd, pat);
        bus.wb_addr = a;
        bus.wb_req  = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.wb_ack) break;
        end
        got = bus.wb_ack;
        bus.wb_req = 1'b0;
        req_check("wb_ack_seen", 192'(got), 192'(1));
        wait_wb_done(d0);
    endtask

    function automatic logic [191:0] out_vec();
        return 192'({bus.fill_ack, bus.fill_data, bus.fill_data_valid, bus.fill_word_idx,
                     bus.fill_done, bus.wb_ack, bus.wb_word_idx, bus.wb_done, bus.busy,
                     bus.mem_write_data, bus.mem_write_addr, bus.mem_write_en,
                     bus.mem_read_addr, bus.mem_read_addr_valid});
    endfunction

    initial begin
        int fd0, wd0, v0;
        bus.fill_req = 1'b0; bus.fill_addr = '0;
        bus.wb_req   = 1'b0; bus.wb_addr   = '0;
        for (int k = 0; k < LW; k++) wb_line[k] = '0;
        repeat (3) @(negedge clk);
        req_check("reset_outputs_zero", out_vec(), 192'(0));
        rst = 1'b1;
        @(negedge clk);

        run_fill(32'h100);
        run_wb(32'h200, 1'b0, 32'hB0);

        // Simultaneous writeback and fill to the same line.
        fd0 = fill_done_cnt; wd0 = wb_done_cnt;
        plan_wb(32'h200, 1'b0, 32'hB0);
        plan_fill(32'h200);
        bus.wb_addr = 32'h200; bus.fill_addr = 32'h200;
        bus.wb_req = 1'b1; bus.fill_req = 1'b1;
        for (int t = 0; t < 400 && (bus.wb_req || bus.fill_req); t++) begin
            @(negedge clk);
            if (bus.wb_ack) bus.wb_req = 1'b0;
            if (bus.fill_ack) bus.fill_req = 1'b0;
        end
        req_check("both_reqs_acked", 192'({bus.wb_req, bus.fill_req}), 192'(0));
        bus.wb_req = 1'b0; bus.fill_req = 1'b0;
        wait_wb_done(wd0);
        wait_fill_done(fd0);

        run_fill(32'h10C);

        stall_q.push_back(5);
        run_fill(32'h300);

        // Reset in the middle of a fill.
        fd0 = fill_done_cnt;
        v0  = fill_valid_cnt;
        plan_fill(32'h140);
        bus.fill_addr = 32'h140;
        bus.fill_req  = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.fill_ack) break;
        end
        bus.fill_req = 1'b0;
        for (int t = 0; t < 500 && fill_valid_cnt < v0 + 2; t++) @(negedge clk);
        req_check("two_words_before_reset", 192'(fill_valid_cnt >= v0 + 2), 192'(1));
        rst = 1'b0;
        @(negedge clk);
        req_check("midop_reset_outputs_zero", out_vec(), 192'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        req_check("no_fill_done_after_reset", 192'(fill_done_cnt), 192'(fd0));
        run_fill(32'h140);

        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] a;
            a = AW'(($urandom_range(0, 31) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) run_wb(a, 1'b1, '0);
            else run_fill(a);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
